// File: rtl/cory_int2_pkg.sv
// Shared types for the interpolate-by-2 stage.
// Phase/full control is encoded as a three-state FSM.
package cory_int2_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_MID   = 2'd1,
        ST_SAMP  = 2'd2
    } int2_state_t;

endpackage

// File: rtl/cory_queue.sv
// Valid/ready output queue of depth D and width W.
// D = 0 degenerates to a combinational pass-through.
module cory_queue #(
    parameter int W = 9,
    parameter int D = 0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_v,
    input  logic [W-1:0] i_d,
    output logic         o_r,
    output logic         o_v,
    output logic [W-1:0] o_d,
    input  logic         i_r
);

    generate
        if (D == 0) begin : g_pass
            logic unused_clk;

            assign o_v        = i_v;
            assign o_d        = i_d;
            assign o_r        = i_r;
            assign unused_clk = clk ^ reset_n;
        end else begin : g_fifo
            localparam int PW = (D > 1) ? $clog2(D) : 1;
            localparam int CW = $clog2(D + 1);
            localparam logic [PW-1:0] LAST = PW'(D - 1);
            localparam logic [CW-1:0] FULL = CW'(D);

            logic [W-1:0]  mem [D];
            logic [PW-1:0] wr_ptr;
            logic [PW-1:0] rd_ptr;
            logic [CW-1:0] count;
            logic          push;
            logic          pop;

            // No push while full, even if the head drains this cycle.
            assign o_r  = (count != FULL);
            assign o_v  = (count != '0);
            assign o_d  = mem[rd_ptr];
            assign push = i_v & o_r;
            assign pop  = o_v & i_r;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    count  <= '0;
                    for (int k = 0; k < D; k++) begin
                        mem[k] <= '0;
                    end
                end else begin
                    if (push) begin
                        mem[wr_ptr] <= i_d;
                        wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
                    end
                    if (pop) begin
                        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
                    end
                    if (push && !pop) begin
                        count <= count + CW'(1);
                    end else if (!push && pop) begin
                        count <= count - CW'(1);
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/cory_int2.sv
// Interpolate-by-2: each input yields a rounded midpoint with the previous
// sample followed by the sample itself; output optionally queued.
module cory_int2
    import cory_int2_pkg::*;
#(
    parameter int N = 8,
    parameter int Q = 0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_a_v,
    input  logic [N-1:0] i_a_d,
    input  logic         i_a_first,
    output logic         o_a_r,
    output logic         o_z_v,
    output logic [N-1:0] o_z_d,
    output logic         o_z_first,
    input  logic         i_z_r
);

    localparam int SW = N + 1;
    localparam int QW = N + 1;

    int2_state_t   state;
    int2_state_t   state_next;
    logic [N-1:0]  cur;
    logic [N-1:0]  prev;
    logic          seg1;
    logic [SW-1:0] sum;
    logic [N-1:0]  mean;
    logic          int_v;
    logic          int_r;
    logic [N-1:0]  int_d;
    logic          int_first;
    logic          in_acc;
    logic          out_acc;
    logic [QW-1:0] z_word;

    // Loading while SAMP drains keeps the output stream bubble-free.
    assign o_a_r   = (state == ST_EMPTY) | ((state == ST_SAMP) & int_r);
    assign in_acc  = i_a_v & o_a_r;
    assign out_acc = int_v & int_r;

    assign sum       = {1'b0, prev} + {1'b0, cur} + SW'(1);
    assign mean      = sum[N:1];
    assign int_v     = (state != ST_EMPTY);
    assign int_d     = (state == ST_SAMP) ? cur : mean;
    assign int_first = (state == ST_MID) & seg1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_EMPTY: if (in_acc) state_next = ST_MID;
            ST_MID:   if (out_acc) state_next = ST_SAMP;
            ST_SAMP: begin
                if (in_acc) begin
                    state_next = ST_MID;
                end else if (out_acc) begin
                    state_next = ST_EMPTY;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    // A segment start aliases prev to the new sample so its midpoint is itself.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur  <= '0;
            prev <= '0;
            seg1 <= 1'b0;
        end else if (in_acc) begin
            cur  <= i_a_d;
            prev <= i_a_first ? i_a_d : cur;
            seg1 <= i_a_first;
        end
    end

    cory_queue #(
        .W (QW),
        .D (Q)
    ) u_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .i_v     (int_v),
        .i_d     ({int_first, int_d}),
        .o_r     (int_r),
        .o_v     (o_z_v),
        .o_d     (z_word),
        .i_r     (i_z_r)
    );

    assign {o_z_first, o_z_d} = z_word;

endmodule

// File: tb/tb_cory_int2.sv
// Directed and model-checked bench for cory_int2 at Q=0, plus a Q=2
// instance exercising output-queue backpressure.
module tb_cory_int2;

    localparam int N = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    logic         a_v, a_first, a_r, z_v, z_first, z_r, z_r_dir;
    logic [N-1:0] a_d, z_d;
    logic         b_a_v, b_a_first, b_a_r, b_z_v, b_z_first, b_z_r;
    logic [N-1:0] b_a_d, b_z_d;

    logic rnd_en = 1'b0;
    logic rnd_bit = 1'b1;
    assign z_r = rnd_en ? rnd_bit : z_r_dir;

    cory_int2 #(.N(N), .Q(0)) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_a_v     (a_v),
        .i_a_d     (a_d),
        .i_a_first (a_first),
        .o_a_r     (a_r),
        .o_z_v     (z_v),
        .o_z_d     (z_d),
        .o_z_first (z_first),
        .i_z_r     (z_r)
    );

    cory_int2 #(.N(N), .Q(2)) u_dut_q2 (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_a_v     (b_a_v),
        .i_a_d     (b_a_d),
        .i_a_first (b_a_first),
        .o_a_r     (b_a_r),
        .o_z_v     (b_z_v),
        .o_z_d     (b_z_d),
        .o_z_first (b_z_first),
        .i_z_r     (b_z_r)
    );

    int         tests_run = 0;
    int         tests_failed = 0;
    int         cycle = 0;
    logic [8:0] got_q[$];
    int         got_cyc[$];
    logic [8:0] exp_q[$];
    logic [8:0] gotb_q[$];
    logic       ar_trace[$];
    logic       trace_en = 1'b0;
    logic       stab_en = 1'b0;
    logic       prev_stall = 1'b0;
    logic [8:0] prev_word = '0;
    int         b_idx;

    always @(posedge clk) cycle <= cycle + 1;

    always @(posedge clk) begin
        #1 rnd_bit = 1'($urandom_range(0, 1));
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Outputs are sampled mid-cycle; a valid&ready seen here transfers at the next edge.
    always @(negedge clk) begin
        if (z_v && z_r) begin
            got_q.push_back({z_first, z_d});
            got_cyc.push_back(cycle);
        end
        if (stab_en && prev_stall) begin
            checkOutput("stall_valid", 32'(z_v), 32'd1);
            checkOutput("stall_data", 32'({z_first, z_d}), 32'(prev_word));
        end
        prev_stall = z_v && !z_r;
        prev_word  = {z_first, z_d};
        if (b_z_v && b_z_r) begin
            gotb_q.push_back({b_z_first, b_z_d});
        end
    end

    task automatic applyStimulus(input logic [N-1:0] d, input logic f);
        int   waited;
        logic accepted;
        waited   = 0;
        accepted = 1'b0;
        a_v      = 1'b1;
        a_d      = d;
        a_first  = f;
        while (!accepted && waited < 200) begin
            @(negedge clk);
            if (trace_en) ar_trace.push_back(a_r);
            if (a_r) accepted = 1'b1;
            else waited++;
        end
        if (!accepted) checkOutput("accept_timeout", 32'(waited), 32'd0);
        @(posedge clk);
        #1;
        a_v = 1'b0;
    endtask

    task automatic expectOut(input logic f, input int d);
        exp_q.push_back({f, 8'(d)});
    endtask

    task automatic clearQueues();
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    task automatic waitDrain(input int limit);
        int w;
        w = 0;
        while (got_q.size() < exp_q.size() && w < limit) begin
            @(posedge clk);
            w++;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic compareQueues(input string name);
        int n;
        checkOutput({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_out%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic stepB(output logic acc);
        @(negedge clk);
        acc = b_a_v & b_a_r;
        @(posedge clk);
        #1;
        if (acc) begin
            b_idx++;
            if (b_idx >= 3) begin
                b_a_v = 1'b0;
            end else begin
                b_a_d     = 8'(5 + b_idx);
                b_a_first = 1'b0;
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0]  rd;
        logic        rf;
        int          mcur;
        int          p;
        int          acc_cnt;
        int          w;
        logic        acc;
        logic [8:0]  exp_b[$];
        logic        exp_ar[7];

        a_v = 1'b0; a_d = '0; a_first = 1'b0; z_r_dir = 1'b1;
        b_a_v = 1'b0; b_a_d = '0; b_a_first = 1'b0; b_z_r = 1'b1;

        #2;
        checkOutput("rst_a_r", 32'(a_r), 32'd1);
        checkOutput("rst_z_v", 32'(z_v), 32'd0);
        checkOutput("rst_z_d", 32'(z_d), 32'd0);
        checkOutput("rst_z_first", 32'(z_first), 32'd0);
        checkOutput("rst_q2_a_r", 32'(b_a_r), 32'd1);
        checkOutput("rst_q2_z_v", 32'(b_z_v), 32'd0);
        checkOutput("rst_q2_z_d", 32'(b_z_d), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] single segment 10,20,31");
        clearQueues();
        expectOut(1, 10); expectOut(0, 10); expectOut(0, 15);
        expectOut(0, 20); expectOut(0, 26); expectOut(0, 31);
        applyStimulus(8'd10, 1'b1);
        applyStimulus(8'd20, 1'b0);
        applyStimulus(8'd31, 1'b0);
        waitDrain(50);
        compareQueues("seg3");

        $display("[TB] back-to-back segments");
        clearQueues();
        expectOut(1, 200); expectOut(0, 200); expectOut(0, 228); expectOut(0, 255);
        expectOut(1, 0);   expectOut(0, 0);   expectOut(0, 1);   expectOut(0, 1);
        applyStimulus(8'd200, 1'b1);
        applyStimulus(8'd255, 1'b0);
        applyStimulus(8'd0, 1'b1);
        applyStimulus(8'd1, 1'b0);
        waitDrain(50);
        compareQueues("b2b");

        $display("[TB] continuous input, ready toggling");
        clearQueues();
        ar_trace.delete();
        expectOut(1, 1); expectOut(0, 1); expectOut(0, 2); expectOut(0, 3);
        expectOut(0, 4); expectOut(0, 5); expectOut(0, 6); expectOut(0, 7);
        trace_en = 1'b1;
        applyStimulus(8'd1, 1'b1);
        applyStimulus(8'd3, 1'b0);
        applyStimulus(8'd5, 1'b0);
        applyStimulus(8'd7, 1'b0);
        trace_en = 1'b0;
        waitDrain(50);
        compareQueues("cont");
        exp_ar = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        checkOutput("ar_trace_len", 32'(ar_trace.size()), 32'd7);
        for (int i = 0; i < 7 && i < ar_trace.size(); i++) begin
            checkOutput($sformatf("ar_trace%0d", i), 32'(ar_trace[i]), 32'(exp_ar[i]));
        end
        checkOutput("no_bubble", (got_cyc.size() == 8) ? 32'(got_cyc[7] - got_cyc[0]) : 32'd0, 32'd7);

        $display("[TB] reset while holding sample");
        z_r_dir = 1'b0;
        applyStimulus(8'd77, 1'b1);
        z_r_dir = 1'b1;
        @(posedge clk);
        #1;
        z_r_dir = 1'b0;
        checkOutput("samp_v", 32'(z_v), 32'd1);
        checkOutput("samp_d", 32'(z_d), 32'd77);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_z_v", 32'(z_v), 32'd0);
        checkOutput("mid_rst_z_d", 32'(z_d), 32'd0);
        checkOutput("mid_rst_a_r", 32'(a_r), 32'd1);
        @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        clearQueues();
        z_r_dir = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("no_stale", 32'(got_q.size()), 32'd0);
        checkOutput("post_rst_a_r", 32'(a_r), 32'd1);

        $display("[TB] random stalls against model");
        clearQueues();
        mcur = 0;
        prev_stall = 1'b0;
        stab_en = 1'b1;
        rnd_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            rd = 8'($urandom_range(0, 255));
            rf = ($urandom_range(0, 7) == 0);
            p = rf ? int'(rd) : mcur;
            expectOut(rf, (p + int'(rd) + 1) / 2);
            expectOut(1'b0, int'(rd));
            mcur = int'(rd);
            applyStimulus(rd, rf);
        end
        waitDrain(200);
        stab_en = 1'b0;
        rnd_en = 1'b0;
        compareQueues("rand");
        checkOutput("rand_2x", 32'(got_q.size()), 32'd2000);

        $display("[TB] Q=2 backpressure");
        gotb_q.delete();
        b_z_r = 1'b0;
        b_idx = 0;
        acc_cnt = 0;
        b_a_d = 8'd5;
        b_a_first = 1'b1;
        b_a_v = 1'b1;
        for (int c = 0; c < 12; c++) begin
            stepB(acc);
            if (acc) acc_cnt++;
        end
        checkOutput("q2_accepted", 32'(acc_cnt), 32'd2);
        checkOutput("q2_a_r_stall", 32'(b_a_r), 32'd0);
        checkOutput("q2_z_v", 32'(b_z_v), 32'd1);
        checkOutput("q2_head", 32'({b_z_first, b_z_d}), 32'({1'b1, 8'd5}));
        checkOutput("q2_none_out", 32'(gotb_q.size()), 32'd0);
        b_z_r = 1'b1;
        w = 0;
        while ((b_idx < 3 || gotb_q.size() < 6) && w < 60) begin
            stepB(acc);
            w++;
        end
        repeat (4) @(posedge clk);
        #1;
        exp_b = '{{1'b1, 8'd5}, {1'b0, 8'd5}, {1'b0, 8'd6},
                  {1'b0, 8'd6}, {1'b0, 8'd7}, {1'b0, 8'd7}};
        checkOutput("q2_count", 32'(gotb_q.size()), 32'd6);
        for (int i = 0; i < 6 && i < gotb_q.size(); i++) begin
            checkOutput($sformatf("q2_out%0d", i), 32'(gotb_q[i]), 32'(exp_b[i]));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
